// File: rtl/pool_requant.sv
// pool_requant: streaming 2x2 / stride-2 max-pool followed by a logical
// right shift and unsigned saturation to OUT_W bits. Pixels arrive in raster
// order; the row pair is joined through a half-width line buffer.
module pool_requant #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 8,
  parameter int MAX_COLS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic [3:0]       rows_m1,
  input  logic [3:0]       cols_m1,
  input  logic [3:0]       shift,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int LB_DEPTH = MAX_COLS / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [IN_W-1:0] OUT_MAX = IN_W'((1 << OUT_W) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, stateNext;
  logic [3:0]        rowCnt, colCnt;
  logic [3:0]        rowsM1Q, colsM1Q, shiftQ;
  logic [3:0]        rowsEff, colsEff, shiftEff;
  logic              lastBeat, emitWin;
  logic [IN_W-1:0]   heldPix, pairMax, winMax;
  logic [IN_W-1:0]   lineBuf [LB_DEPTH];
  logic [LB_AW-1:0]  lbIdx;
  logic [OUT_W-1:0]  outData_p1;
  logic              vld_p1, frameDone_p1, busy_p1;

  function automatic logic [IN_W-1:0] maxU(input logic [IN_W-1:0] a,
                                           input logic [IN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Logical shift, then clamp to the largest unsigned OUT_W value.
  function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] v,
                                               input logic [3:0]      sh);
    logic [IN_W-1:0] s;
    s = v >> sh;
    return (s > OUT_MAX) ? '1 : s[OUT_W-1:0];
  endfunction

  // Stage p0: frame geometry, window maximum and next-state decode.
  // In IDLE the live configuration applies, since that beat is pixel (0,0).
  always_comb begin
    stateNext = state;
    rowsEff   = (state == IDLE) ? rows_m1 : rowsM1Q;
    colsEff   = (state == IDLE) ? cols_m1 : colsM1Q;
    shiftEff  = (state == IDLE) ? shift   : shiftQ;
    lbIdx     = LB_AW'(colCnt >> 1);
    lastBeat  = in_valid && (rowCnt == rowsEff) && (colCnt == colsEff);
    emitWin   = in_valid && rowCnt[0] && colCnt[0];
    pairMax   = maxU(heldPix, in_data);
    winMax    = maxU(lineBuf[lbIdx], pairMax);
    case (state)
      IDLE:    if (in_valid && !lastBeat) stateNext = RUN;
      RUN:     if (lastBeat) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Control state: FSM, raster counters, configuration latch, output stage p1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rowCnt       <= '0;
      colCnt       <= '0;
      rowsM1Q      <= '0;
      colsM1Q      <= '0;
      shiftQ       <= '0;
      outData_p1   <= '0;
      vld_p1       <= 1'b0;
      frameDone_p1 <= 1'b0;
      busy_p1      <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && in_valid) begin
        rowsM1Q <= rows_m1;
        colsM1Q <= cols_m1;
        shiftQ  <= shift;
      end
      if (in_valid) begin
        if (lastBeat) begin
          rowCnt <= '0;
          colCnt <= '0;
        end else if (colCnt == colsEff) begin
          colCnt <= '0;
          rowCnt <= rowCnt + 4'd1;
        end else begin
          colCnt <= colCnt + 4'd1;
        end
      end
      // Stage p1: registered results, one cycle after the completing beat.
      vld_p1       <= emitWin;
      frameDone_p1 <= lastBeat;
      busy_p1      <= (stateNext == RUN);
      if (emitWin) outData_p1 <= requant(winMax, shiftEff);
    end
  end

  // Datapath storage: even-column pixel hold and even-row pair maxima.
  always_ff @(posedge clk) begin
    if (in_valid && !colCnt[0]) heldPix <= in_data;
    if (in_valid && colCnt[0] && !rowCnt[0]) lineBuf[lbIdx] <= pairMax;
  end

  assign out_data   = outData_p1;
  assign out_valid  = vld_p1;
  assign frame_done = frameDone_p1;
  assign busy       = busy_p1;

endmodule

// File: doc/pool_requant.md
POOL_REQUANT -- requirements
Module: pool_requant

Interface
REQ-001 Parameter IN_W, default 16: width of each incoming convolution result.
REQ-002 Parameter OUT_W, default 8: width of each requantised output sample.
REQ-003 Parameter MAX_COLS, default 16: maximum input columns; sets the line-buffer depth to MAX_COLS/2 entries of IN_W bits.
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  IN_W  unsigned convolution result, raster order, row-major.
REQ-008 in_valid  input  1  in_data is a valid beat this cycle; gaps allowed.
REQ-009 rows_m1  input  4  input row count minus 1.
REQ-010 cols_m1  input  4  input column count minus 1.
REQ-011 shift  input  4  right-shift applied before saturation.
REQ-012 out_data  output  OUT_W  pooled, requantised sample.
REQ-013 out_valid  output  1  out_data valid, one-cycle pulse per sample.
REQ-014 frame_done  output  1  one-cycle pulse after the last input beat of a frame.
REQ-015 busy  output  1  high while a frame is partially received.

Function
REQ-016 The block SHALL compute a 2x2, stride-2 max-pool over an R x C input (R=rows_m1+1, C=cols_m1+1), producing floor(R/2) x floor(C/2) outputs in raster order.
REQ-017 Odd trailing row or column SHALL be consumed and discarded; no output is produced for it.
REQ-018 FSM states: IDLE, RUN. IDLE->RUN on in_valid; RUN->IDLE on the beat at (R-1, C-1); a frame of exactly one beat SHALL go IDLE->IDLE.
REQ-019 The first beat seen in IDLE SHALL be pixel (0,0); rows_m1, cols_m1 and shift SHALL be latched on that beat; changes during RUN SHALL be ignored.
REQ-020 Row counter r and column counter c SHALL advance only on in_valid beats; c wraps to 0 after C-1 and increments r.
REQ-021 Even column beats SHALL be held in a register; on odd column beats the pair maximum SHALL be formed.
REQ-022 On even rows the pair maximum SHALL be written to line-buffer entry c>>1.
REQ-023 On odd rows at odd c, the window maximum = max(line-buffer[c>>1], pair maximum) SHALL be requantised and presented.
REQ-024 Requantisation: v = window maximum >> shift (logical); out_data = v if v <= 2^OUT_W-1, else 2^OUT_W-1.
REQ-025 Latency: out_valid SHALL rise exactly 1 cycle after the in_valid beat completing the window.
REQ-026 out_data SHALL hold its last value while out_valid is low.
REQ-027 frame_done SHALL pulse 1 cycle after the final beat, coincident with the last out_valid when one exists.
REQ-028 busy SHALL be high from the cycle after the first beat until the cycle after the final beat; it SHALL be low for a one-beat frame.
REQ-029 A beat arriving on the cycle RUN returns to IDLE cannot occur; the next beat after frame completion SHALL start a new frame at (0,0) with no idle cycle required.
REQ-030 Comparisons SHALL be unsigned, full IN_W width; ties have no observable effect.

Reset
REQ-031 While rst_n is low: state=IDLE, r=c=0, out_data=0, out_valid=0, frame_done=0, busy=0.
REQ-032 Line-buffer and held-pixel contents need no reset; every entry SHALL be written before it is read.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; the first beat after release SHALL be treated as pixel (0,0).

Verification
REQ-034 4x4 input 1..16, shift=0 -> outputs 6, 8, 14, 16, each 1 cycle after beats (1,1), (1,3), (3,1), (3,3); frame_done with the last.
REQ-035 3x5 input, all beats 0x0200, shift=1 -> 2 outputs of 0xFF (0x100 saturated); row 2 and column 4 discarded; frame_done 1 cycle after beat 15.
REQ-036 4x4 input 0x0400 at (0,0), else 0, shift=4 -> first output 0x40, rest 0; in_valid gap of 3 cycles mid-row changes no values.
REQ-037 rows_m1=0, cols_m1=0, one beat -> no out_valid, frame_done 1 cycle later, busy stays 0.
REQ-038 rst_n pulsed low after 6 beats of a 4x4 frame -> all outputs 0 immediately; a complete 2x2 frame of 9,3,7,5, shift=0, afterward -> single output 9.
